// File: rtl/weight_tile_replay_buffer_if.sv
// Stream bundle for weight_tile_replay_buffer.
// Capture side: data_in / data_in_valid / data_in_ready.
// Replay side: data_out / data_out_valid / data_out_ready / data_out_last, plus done.
// Handshake: a beat moves on a rising clk edge where valid && ready. Once valid is
// raised it stays high, with data and last held stable, until that edge.
interface weight_tile_replay_buffer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 1
);
  logic [DATA_WIDTH-1:0] data_in  [PARALLELISM];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [PARALLELISM];
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;
  logic                  done;

  // The buffer itself
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last, done
  );

  // Source and consumer side
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last, done
  );
endinterface

// File: rtl/weight_tile_replay_buffer.sv
// Weight tile replay buffer: captures one pass of DEPTH beats from a weight source,
// then replays that pass REPEAT times downstream so the source is read once per layer.
// Replay path: mem read register (1 cycle) -> output register + 1 skid register.
// Reads are issued only when the output pair is guaranteed room, which gives
// one beat per cycle under continuous data_out_ready, including across passes.
module weight_tile_replay_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 1,
  parameter int DEPTH       = 32,
  parameter int REPEAT      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  weight_tile_replay_buffer_if.slave   bus,
  output logic                         dbg_state
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int REP_W = $clog2(REPEAT) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEAT - 1);
  localparam logic [REP_W-1:0] REP_END  = REP_W'(REPEAT);

  typedef enum logic [0:0] {FILL = 1'b0, REPLAY = 1'b1} state_e;

  // Control state
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               done_q, done_d;

  // Read stage (memory output register)
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               rd_final_q, rd_final_d;
  logic [DATA_WIDTH-1:0] rd_data_q [PARALLELISM];
  logic [DATA_WIDTH-1:0] rd_data_d [PARALLELISM];

  // Output register (head) and skid register (second entry)
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               out_final_q, out_final_d;
  logic [DATA_WIDTH-1:0] out_data_q [PARALLELISM];
  logic [DATA_WIDTH-1:0] out_data_d [PARALLELISM];
  logic               skid_valid_q, skid_valid_d;
  logic               skid_last_q, skid_last_d;
  logic               skid_final_q, skid_final_d;
  logic [DATA_WIDTH-1:0] skid_data_q [PARALLELISM];
  logic [DATA_WIDTH-1:0] skid_data_d [PARALLELISM];

  // Weight storage, not cleared by reset
  logic [DATA_WIDTH-1:0] mem_q [DEPTH][PARALLELISM];

  logic               in_hs;
  logic               out_hs;
  logic               wr_en;
  logic [1:0]         occ;
  logic               room;

  assign in_hs  = in_ready_q  & bus.data_in_valid;
  assign out_hs = out_valid_q & bus.data_out_ready;

  // Next-state logic: capture, read issue, output/skid movement and end of replay
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rep_cnt_d    = rep_cnt_q;
    in_ready_d   = in_ready_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    rd_valid_d   = 1'b0;
    rd_last_d    = rd_last_q;
    rd_final_d   = rd_final_q;
    rd_data_d    = rd_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_final_d  = out_final_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_final_d = skid_final_q;
    skid_data_d  = skid_data_q;

    // Beats held or in flight; a new read may issue if, after this cycle's pop,
    // at most one beat remains committed, so the issued beat always finds a slot.
    occ  = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};
    room = (occ - {1'b0, out_hs}) < 2'd2;

    case (state_q)
      FILL: begin
        if (in_hs) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d   = '0;
            state_d    = REPLAY;
            in_ready_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      REPLAY: begin
        // rep_cnt reaching REPEAT means every beat of every pass has been read
        if (room && (rep_cnt_q != REP_END)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
          rd_last_d  = (rd_ptr_q == LAST_PTR);
          rd_final_d = (rd_ptr_q == LAST_PTR) && (rep_cnt_q == LAST_REP);
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d  = '0;
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase

    // Head advances only when empty or popped, so a stalled beat never changes
    if (!out_valid_q || out_hs) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_final_d  = skid_final_q;
        out_data_d   = skid_data_q;
        skid_valid_d = rd_valid_q;
        skid_last_d  = rd_last_q;
        skid_final_d = rd_final_q;
        skid_data_d  = rd_data_q;
      end else begin
        out_valid_d  = rd_valid_q;
        out_last_d   = rd_valid_q ? rd_last_q : 1'b0;
        out_final_d  = rd_valid_q ? rd_final_q : 1'b0;
        if (rd_valid_q) out_data_d = rd_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (rd_valid_q) begin
      skid_valid_d = 1'b1;
      skid_last_d  = rd_last_q;
      skid_final_d = rd_final_q;
      skid_data_d  = rd_data_q;
    end

    // Final beat of the final pass consumed: back to capture
    if ((state_q == REPLAY) && out_hs && out_final_q) begin
      state_d      = FILL;
      in_ready_d   = 1'b1;
      done_d       = 1'b1;
      rd_ptr_d     = '0;
      rep_cnt_d    = '0;
      rd_valid_d   = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // Control and valid flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rep_cnt_q    <= '0;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_final_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_final_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_final_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rep_cnt_q    <= rep_cnt_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_final_q   <= rd_final_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_final_q  <= out_final_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_final_q <= skid_final_d;
    end
  end

  // Data-path registers; contents qualified by the valid flops above
  always_ff @(posedge clk) begin
    rd_data_q   <= rd_data_d;
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  // Capture write into storage
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  assign bus.data_in_ready  = in_ready_q;
  assign bus.data_out       = out_data_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.data_out_last  = out_last_q;
  assign bus.done           = done_q;
  assign dbg_state          = state_q;

endmodule
